// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared processor constants, port indices and arbiter FSM encoding
package ram_port_arbiter_pkg;

  localparam int DATA_SIZE    = 32;
  localparam int ADDRESS_SIZE = 16;

  // Port indices used by the round-robin arbiter and the grant latch
  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin choice, favouring the port not granted last
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // A lone requester wins; on a tie the port that did not win last time goes first
  always_comb begin
    grant = PORT_P0;
    if (req == 2'b11) begin
      grant = (last == PORT_P0) ? PORT_P1 : PORT_P0;
    end else if (req[1]) begin
      grant = PORT_P1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter sequencing single-word accesses onto a change-triggered RAM
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = ram_port_arbiter_pkg::DATA_SIZE,
  parameter int ADDRESS_SIZE = ram_port_arbiter_pkg::ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDRESS_SIZE-1:0] p0_addr,
  input  logic [DATA_SIZE-1:0]    p0_wdata,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDRESS_SIZE-1:0] p1_addr,
  input  logic [DATA_SIZE-1:0]    p1_wdata,
  output logic                    p0_ack,
  output logic                    p1_ack,
  output logic [DATA_SIZE-1:0]    rdata,
  output logic                    busy,
  output logic                    ram_read_write,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [DATA_SIZE-1:0]    ram_data_in,
  input  logic [DATA_SIZE-1:0]    ram_data_out
);

  arb_state_t state, state_nxt;

  logic                    grant;
  logic                    last;
  logic                    any_req;
  logic                    lat_port;
  logic                    lat_we;
  logic [ADDRESS_SIZE-1:0] lat_addr;
  logic [DATA_SIZE-1:0]    lat_wdata;
  logic                    sel_we;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [DATA_SIZE-1:0]    sel_wdata;

  assign any_req = p0_req | p1_req;

  rr_arbiter2 u_rr (
    .req   ({p1_req, p0_req}),
    .last  (last),
    .grant (grant)
  );

  // Request fields of whichever port the arbiter picks this cycle
  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (grant == PORT_P1) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: only IDLE waits; the access phases always advance
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_ADDR;
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: write mode only in DATA, ack only in RESP
  always_comb begin
    busy           = (state != ST_IDLE);
    ram_read_write = !((state == ST_DATA) && lat_we);
    p0_ack         = (state == ST_RESP) && (lat_port == PORT_P0);
    p1_ack         = (state == ST_RESP) && (lat_port == PORT_P1);
  end

  // Grant latch: freeze the winning request so later input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= PORT_P1;
      lat_port  <= PORT_P0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if ((state == ST_IDLE) && any_req) begin
      last      <= grant;
      lat_port  <= grant;
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // RAM datapath: inverse data in ADDR then true data in DATA guarantees a change in write mode
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_address <= '0;
      ram_data_in <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            ram_address <= sel_addr;
            if (sel_we) ram_data_in <= ~sel_wdata;
          end
        end
        ST_ADDR: begin
          if (lat_we) ram_data_in <= lat_wdata;
        end
        ST_DATA: begin
          if (!lat_we) rdata <= ram_data_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter with a change-triggered RAM model
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack, busy, ram_read_write;
  logic [31:0] rdata, ram_data_in, ram_data_out;
  logic [15:0] ram_address;

  logic [31:0] mem [0:65535];
  logic [31:0] prev_din;
  logic        preload;

  int checks = 0;
  int errors = 0;

  logic [15:0] p0_vec, p1_vec;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p0_ack         (p0_ack),
    .p1_ack         (p1_ack),
    .rdata          (rdata),
    .busy           (busy),
    .ram_read_write (ram_read_write),
    .ram_address    (ram_address),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out)
  );

  assign ram_data_out = mem[ram_address];

  // RAM model: writes only when the data input has changed while in write mode
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      mem[4] = 32'h0000_00AA;
    end else if (!ram_read_write && (ram_data_in != prev_din)) begin
      mem[ram_address] = ram_data_in;
    end
    prev_din = ram_data_in;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction from an IDLE cycle; inputs are scrambled after the grant
  task automatic run_txn(input string tag, input logic port, input logic we,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata);
    logic [3:0]  rw_v, busy_v, a0_v, a1_v;
    logic [31:0] din_a, din_d, addr_a, rd_r;
    rw_v = '0; busy_v = '0; a0_v = '0; a1_v = '0;
    din_a = '0; din_d = '0; addr_a = '0; rd_r = '0;
    @(negedge clk);
    if (port == 1'b0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rw_v[i]   = ram_read_write;
      busy_v[i] = busy;
      a0_v[i]   = p0_ack;
      a1_v[i]   = p1_ack;
      if (i == 0) begin
        addr_a   = {16'h0, ram_address};
        din_a    = ram_data_in;
        p0_req   = 1'b0; p1_req = 1'b0;
        p0_we    = ~p0_we; p1_we = ~p1_we;
        p0_addr  = ~p0_addr; p1_addr = ~p1_addr;
        p0_wdata = ~p0_wdata; p1_wdata = ~p1_wdata;
      end
      if (i == 1) din_d = ram_data_in;
      if (i == 2) rd_r = rdata;
    end
    check_val({tag, "_busy"}, {28'h0, busy_v}, 32'h7);
    check_val({tag, "_rw"}, {28'h0, rw_v}, {28'h0, 2'b11, ~we, 1'b1});
    check_val({tag, "_p0ack"}, {28'h0, a0_v}, (port == 1'b0) ? 32'h4 : 32'h0);
    check_val({tag, "_p1ack"}, {28'h0, a1_v}, (port == 1'b1) ? 32'h4 : 32'h0);
    check_val({tag, "_addr"}, addr_a, {16'h0, addr});
    if (we) begin
      check_val({tag, "_din_addr"}, din_a, ~wdata);
      check_val({tag, "_din_data"}, din_d, wdata);
    end
    check_val({tag, "_rdata"}, rd_r, exp_rdata);
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    p0_vec = '0; p1_vec = '0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;

    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_rw", {31'h0, ram_read_write}, 32'h1);
    check_val("rst_addr", {16'h0, ram_address}, 32'h0);
    check_val("rst_din", ram_data_in, 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_acks", {30'h0, p1_ack, p0_ack}, 32'h0);

    run_txn("p0_rd4",   1'b0, 1'b0, 16'h0004, 32'h0,         32'h0000_00AA);
    run_txn("p1_wr10",  1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 32'h0000_00AA);
    check_val("p1_wr10_mem", mem[16'h0010], 32'hDEAD_BEEF);
    run_txn("p0_rd10",  1'b0, 1'b0, 16'h0010, 32'h0,         32'hDEAD_BEEF);
    run_txn("p0_wr20a", 1'b0, 1'b1, 16'h0020, 32'h1234_5678, 32'hDEAD_BEEF);
    run_txn("p0_rd20a", 1'b0, 1'b0, 16'h0020, 32'h0,         32'h1234_5678);
    run_txn("p1_wr20z", 1'b1, 1'b1, 16'h0020, 32'h0,         32'h1234_5678);
    run_txn("p1_rd20z", 1'b1, 1'b0, 16'h0020, 32'h0,         32'h0);
    run_txn("p0_wr20b", 1'b0, 1'b1, 16'h0020, 32'h1234_5678, 32'h0);
    run_txn("p0_rd20b", 1'b0, 1'b0, 16'h0020, 32'h0,         32'h1234_5678);

    // Reset raised while a p0 write sits in DATA
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0030; p0_wdata = 32'h0000_0055;
    @(negedge clk);
    p0_req = 1'b0;
    @(negedge clk);
    check_val("abort_data_rw", {31'h0, ram_read_write}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_busy", {31'h0, busy}, 32'h0);
    check_val("abort_rw", {31'h0, ram_read_write}, 32'h1);
    check_val("abort_ack", {30'h0, p1_ack, p0_ack}, 32'h0);
    check_val("abort_din", ram_data_in, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_ack_after", {30'h0, p1_ack, p0_ack}, 32'h0);
    check_val("abort_busy_after", {31'h0, busy}, 32'h0);

    // Both ports requesting continuously from reset
    rst = 1'b1;
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0004;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0010;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      p0_vec[i] = p0_ack;
      p1_vec[i] = p1_ack;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check_val("rr_p0_grants", {16'h0, p0_vec}, 32'h0000_0404);
    check_val("rr_p1_grants", {16'h0, p1_vec}, 32'h0000_4040);
    check_val("rr_no_overlap", {16'h0, p0_vec & p1_vec}, 32'h0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
